line_buffer: RTL

- Parametrised multi-row delay for the vertical part of the 2-D stream filter.
- Takes one pixel stream and presents LINES vertically aligned pixels per column: the current row plus LINES-1 previous rows.
- Runtime row width; valid/ready handshake on both sides.
- Suppresses output until the window is primed, and flags end-of-row.

---
 rtl/line_buffer_pkg.sv | 24 ++
 rtl/line_buffer_delay_ram.sv | 24 ++
 rtl/line_buffer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line buffer and the horizontal filter: window-height
// check, dn_data slice macro, stage flag struct and the row-width clamp.
`ifndef LINE_BUFFER_DEFS
`define LINE_BUFFER_DEFS
`define LB_LINES_OK(n) ((n) >= 2)
`define LB_SLICE(k, w) ((k)*(w)) +: (w)
`endif

package line_buffer_pkg;

  typedef struct packed {
    logic val;
    logic last;
    logic primed;
  } stage_flags_t;

  localparam int unsigned MIN_WIDTH = 2;

  // Rows narrower than two columns would let the read and write-back addresses collide.
  function automatic int unsigned clamp_width(input int unsigned req, input int unsigned depth);
    return (req < MIN_WIDTH) ? MIN_WIDTH : ((req > depth) ? depth : req);
  endfunction

endpackage

// File: rtl/line_buffer_delay_ram.sv
// Simple-dual-port synchronous RAM with registered read data and no reset;
// shared by the delay blocks of the stream filter.
module delay_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer.sv
// Multi-row delay: presents LINES vertically aligned pixels per column once
// LINES-1 complete rows have been stored, with a 2-stage valid/ready pipeline.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int LINES      = 3,
  parameter int MEM_AWIDTH = 12,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEM_AWIDTH:0]        cfg_width,
  input  logic                       cfg_set,
  input  logic [IMG_WIDTH-1:0]       up_data,
  input  logic                       up_val,
  output logic                       up_rdy,
  output logic [LINES*IMG_WIDTH-1:0] dn_data,
  output logic                       dn_last,
  output logic                       dn_val,
  input  logic                       dn_rdy,
  output logic                       primed
);

  localparam int RAM_W = (LINES - 1) * IMG_WIDTH;
  localparam int RW    = $clog2(LINES);
  localparam logic [MEM_AWIDTH:0]   DEPTH_W  = (MEM_AWIDTH+1)'(MEM_DEPTH);
  localparam logic [MEM_AWIDTH:0]   ONE_W    = (MEM_AWIDTH+1)'(1);
  localparam logic [MEM_AWIDTH-1:0] ONE_C    = MEM_AWIDTH'(1);
  localparam logic [RW-1:0]         ROW_FULL = RW'(LINES - 1);
  localparam logic [RW-1:0]         ONE_R    = RW'(1);

  generate
    if (!`LB_LINES_OK(LINES)) begin : g_lines_check
      $error("line_buffer: LINES must be at least 2");
    end
  endgenerate

  logic [MEM_AWIDTH:0]        width_r;
  logic [MEM_AWIDTH-1:0]      col;
  logic [RW-1:0]              row_cnt;
  logic [RW-1:0]              row_next;
  stage_flags_t               s1;
  logic [IMG_WIDTH-1:0]       s1_pix;
  logic [MEM_AWIDTH-1:0]      s1_col;
  logic [RAM_W-1:0]           ram_q;
  logic [RAM_W-1:0]           wdata;
  logic [LINES*IMG_WIDTH-1:0] window;
  logic                       advance;
  logic                       accept;
  logic                       col_last;
  logic                       ram_we;

  assign advance  = !dn_val || dn_rdy;
  assign up_rdy   = advance && !cfg_set;
  assign accept   = up_val && up_rdy;
  assign col_last = ({1'b0, col} == (width_r - ONE_W));
  assign ram_we   = advance && s1.val && !cfg_set;

  always_comb begin
    row_next = row_cnt;
    if (row_cnt != ROW_FULL) row_next = row_cnt + ONE_R;
  end

  // Slice 0 is the pixel in flight; older rows come straight from the RAM word.
  assign window[`LB_SLICE(0, IMG_WIDTH)] = s1_pix;
  genvar gi;
  generate
    for (gi = 1; gi < LINES; gi++) begin : g_window
      assign window[`LB_SLICE(gi, IMG_WIDTH)] = ram_q[`LB_SLICE(gi - 1, IMG_WIDTH)];
    end
    if (LINES == 2) begin : g_wb_single
      assign wdata = s1_pix;
    end else begin : g_wb_shift
      assign wdata = {ram_q[(LINES-2)*IMG_WIDTH-1:0], s1_pix};
    end
  endgenerate

  delay_ram #(
    .DATA_W (RAM_W),
    .ADDR_W (MEM_AWIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s1_col),
    .wdata (wdata),
    .re    (accept),
    .raddr (col),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_r <= DEPTH_W;
      col     <= '0;
      row_cnt <= '0;
      primed  <= 1'b0;
      s1      <= '0;
      s1_pix  <= '0;
      s1_col  <= '0;
      dn_val  <= 1'b0;
      dn_data <= '0;
      dn_last <= 1'b0;
    end else if (cfg_set) begin
      width_r <= (MEM_AWIDTH+1)'(clamp_width(32'(cfg_width), MEM_DEPTH));
      col     <= '0;
      row_cnt <= '0;
      primed  <= 1'b0;
      s1      <= '0;
      dn_val  <= 1'b0;
    end else begin
      if (accept) begin
        s1.val    <= 1'b1;
        s1.last   <= col_last;
        s1.primed <= primed;
        s1_pix    <= up_data;
        s1_col    <= col;
        if (col_last) begin
          col     <= '0;
          row_cnt <= row_next;
          primed  <= (row_next == ROW_FULL);
        end else begin
          col <= col + ONE_C;
        end
      end else if (advance) begin
        s1.val <= 1'b0;
      end
      // Unprimed columns still refresh the RAM but are never presented downstream.
      if (advance) begin
        dn_val <= s1.val && s1.primed;
        if (s1.val && s1.primed) begin
          dn_data <= window;
          dn_last <= s1.last;
        end
      end
    end
  end

endmodule
